mem_wb_stage: RTL

Memory-access stage of the pipelined MIPS datapath. It takes the instruction leaving EX/MEM and issues its load/store to the data cache, holding the request until `dhit`. It stalls upstream latches while the access is outstanding. It produces the registered MEM/WB latch contents, with final writeback register select and data already resolved, so the WB stage and register file consume them directly.

---
 rtl/mem_wb_stage_if.sv | 19 +
 rtl/mem_wb_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-cache port seen from the memory stage: request out, hit/load data back.
interface mem_wb_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage: issues the EX/MEM load/store to the data cache, holds it until
// dhit, stalls upstream meanwhile, and registers a fully resolved MEM/WB latch.
module mem_wb_stage #(
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        validEX,
  input  logic [31:0] instrEX,
  input  logic [31:0] pcEX,
  input  logic [31:0] resultEX,
  input  logic [31:0] rdat2EX,
  input  logic        dRENEX,
  input  logic        dWENEX,
  input  logic        rf_writeEX,
  input  logic        memtoregEX,
  input  logic        reg_dstEX,
  input  logic        j_alEX,
  input  logic        haltEX,
  mem_wb_stage_if.master dmem,
  output logic        stall,
  output logic        validWB,
  output logic        rf_writeWB,
  output logic        haltWB,
  output logic [4:0]  wselWB,
  output logic [31:0] wdatWB,
  output logic [31:0] instrWB,
  output logic [31:0] pcWB
);

  typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

  // Access parked while the cache works on it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] store;
    logic        ren;
    logic        wen;
    logic        rfw;
    logic        m2r;
    logic        rdst;
    logic        jal;
  } hold_t;

  typedef struct packed {
    logic        valid;
    logic        rfw;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] instr;
    logic [31:0] pc;
  } wb_t;

  state_t state_q, state_d;
  hold_t  hold_q, hold_d;
  wb_t    wb_q, wb_d;

  // Final register select / data so WB needs no further muxing.
  function automatic wb_t resolve(
    input logic [31:0] instr, input logic [31:0] pc,
    input logic [31:0] result, input logic [31:0] load,
    input logic rfw, input logic m2r, input logic rdst,
    input logic jal, input logic halt
  );
    wb_t w;
    w.valid = 1'b1;
    w.halt  = halt;
    w.instr = instr;
    w.pc    = pc;
    w.wsel  = jal ? LINK_REG : (rdst ? instr[15:11] : instr[20:16]);
    w.wdat  = jal ? (pc + PC_INC) : (m2r ? load : result);
    w.rfw   = rfw & (w.wsel != 5'd0);
    return w;
  endfunction

  // Next-state, hold capture and MEM/WB latch contents.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (!validEX) begin
          wb_d.valid = 1'b0;
          wb_d.rfw   = 1'b0;
          wb_d.halt  = 1'b0;
        end else if (haltEX) begin
          // Memory flags on a halt are deliberately ignored.
          wb_d    = resolve(instrEX, pcEX, resultEX, dmem.dmemload, rf_writeEX,
                            memtoregEX, reg_dstEX, j_alEX, 1'b1);
          state_d = HALTED;
        end else if (dRENEX | dWENEX) begin
          hold_d.instr = instrEX;
          hold_d.pc    = pcEX;
          hold_d.addr  = resultEX;
          hold_d.store = rdat2EX;
          hold_d.ren   = dRENEX;
          hold_d.wen   = dWENEX;
          hold_d.rfw   = rf_writeEX;
          hold_d.m2r   = memtoregEX;
          hold_d.rdst  = reg_dstEX;
          hold_d.jal   = j_alEX;
          wb_d.valid   = 1'b0;
          wb_d.rfw     = 1'b0;
          wb_d.halt    = 1'b0;
          state_d      = REQ;
        end else begin
          wb_d = resolve(instrEX, pcEX, resultEX, dmem.dmemload, rf_writeEX,
                         memtoregEX, reg_dstEX, j_alEX, 1'b0);
        end
      end
      REQ: begin
        if (dmem.dhit) begin
          wb_d    = resolve(hold_q.instr, hold_q.pc, hold_q.addr, dmem.dmemload,
                            hold_q.rfw, hold_q.m2r, hold_q.rdst, hold_q.jal, 1'b0);
          state_d = IDLE;
        end else begin
          wb_d.valid = 1'b0;
          wb_d.rfw   = 1'b0;
        end
      end
      HALTED: begin
        wb_d.valid = 1'b0;
        wb_d.rfw   = 1'b0;
        wb_d.halt  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, hold and MEM/WB registers; reset discards any held access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
    end
  end

  // Cache request straight off the hold registers; a write wins over a read.
  always_comb begin
    dmem.dmemREN   = (state_q == REQ) & hold_q.ren & ~hold_q.wen;
    dmem.dmemWEN   = (state_q == REQ) & hold_q.wen;
    dmem.dmemaddr  = (state_q == REQ) ? hold_q.addr  : 32'd0;
    dmem.dmemstore = (state_q == REQ) ? hold_q.store : 32'd0;
    // Released in the hit cycle so upstream advances on the retiring edge.
    stall = ((state_q == REQ) & ~dmem.dhit) | (state_q == HALTED);
  end

  assign validWB    = wb_q.valid;
  assign rf_writeWB = wb_q.rfw;
  assign haltWB     = wb_q.halt;
  assign wselWB     = wb_q.wsel;
  assign wdatWB     = wb_q.wdat;
  assign instrWB    = wb_q.instr;
  assign pcWB       = wb_q.pc;

endmodule
